cmd_frame_decoder: RTL and testbench

//  Assembles the byte stream from the SPI slave (newData pulse + byte) into framed, checksummed commands.

---
 rtl/cmd_frame_pkg.sv | 8 +
 rtl/cmd_frame_decoder_if.sv | 22 ++
 rtl/cmd_timeout_counter.sv | 18 +
 rtl/cmd_frame_decoder.sv | 120 ++++++++++++
 tb/tb_cmd_frame_decoder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared FSM encoding, frame header constant and payload byte count helper
package cmd_frame_pkg;
  typedef enum logic [1:0] {IDLE, INDEX, DATA, CHECK} state_t;
  localparam logic [7:0] CMD_HEADER = 8'hA5;
  function automatic int nb_of(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/cmd_frame_decoder_if.sv
// cmd_frame_decoder_if: byte-stream input and target/status outputs of the command frame decoder
interface cmd_frame_decoder_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 32
);
  logic CMD_FRAME_DECODER_newData_In;
  logic [7:0] CMD_FRAME_DECODER_data_InBus;
  logic [NUM_CH*DATA_WIDTH-1:0] CMD_FRAME_DECODER_TARGETS_OutBus;
  logic CMD_FRAME_DECODER_UPDATE_Out;
  logic CMD_FRAME_DECODER_ERROR_Out;
  logic CMD_FRAME_DECODER_TIMEOUT_Out;
  modport master (
    output CMD_FRAME_DECODER_newData_In, CMD_FRAME_DECODER_data_InBus,
    input CMD_FRAME_DECODER_TARGETS_OutBus, CMD_FRAME_DECODER_UPDATE_Out,
    input CMD_FRAME_DECODER_ERROR_Out, CMD_FRAME_DECODER_TIMEOUT_Out
  );
  modport slave (
    input CMD_FRAME_DECODER_newData_In, CMD_FRAME_DECODER_data_InBus,
    output CMD_FRAME_DECODER_TARGETS_OutBus, CMD_FRAME_DECODER_UPDATE_Out,
    output CMD_FRAME_DECODER_ERROR_Out, CMD_FRAME_DECODER_TIMEOUT_Out
  );
endinterface

// File: rtl/cmd_timeout_counter.sv
// cmd_timeout_counter: saturating cycle counter that flags when LIMIT is reached
module cmd_timeout_counter #(
  parameter int LIMIT = 50_000
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  input logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] count;
  assign expired = count == W'(LIMIT);
  // count up until LIMIT and hold there; clear has priority
  always_ff @(posedge clk)
    if (!rst_n || clear) count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
endmodule

// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: frames SPI bytes into checksummed target writes; CMD_WATCHDOG_EN adds a link-loss failsafe
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_TIMEOUT = 50_000,
  parameter int WDOG_CYCLES = 5_000_000
) (
  input logic CMD_FRAME_DECODER_CLOCK_50,
  input logic CMD_FRAME_DECODER_RESET_InLow,
  cmd_frame_decoder_if.slave bus
);
  localparam int NB = nb_of(DATA_WIDTH);
  localparam int CW = $clog2(NB + 1);
  if (NUM_CH < 1 || NUM_CH > 255 || DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0 || BYTE_TIMEOUT < 1 || WDOG_CYCLES < 1)
    begin : g_bad_params
      $error("cmd_frame_decoder: invalid parameters");
    end
  logic clk, rst_n, strobe;
  logic [7:0] din;
  state_t state, state_n;
  logic [7:0] idx, acc;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] shadow;
  logic [NUM_CH*DATA_WIDTH-1:0] targets;
  logic valid, err, update, error, byte_expired;
  assign clk = CMD_FRAME_DECODER_CLOCK_50;
  assign rst_n = CMD_FRAME_DECODER_RESET_InLow;
  assign strobe = bus.CMD_FRAME_DECODER_newData_In;
  assign din = bus.CMD_FRAME_DECODER_data_InBus;
  assign bus.CMD_FRAME_DECODER_TARGETS_OutBus = targets;
  assign bus.CMD_FRAME_DECODER_UPDATE_Out = update;
  assign bus.CMD_FRAME_DECODER_ERROR_Out = error;
  // idle gap counter: runs only inside a frame, restarts on every byte
  cmd_timeout_counter #(.LIMIT(BYTE_TIMEOUT)) u_byte_to (
    .clk(clk), .rst_n(rst_n), .clear(strobe || state_n == IDLE), .enable(1'b1), .expired(byte_expired)
  );
  // frame state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state plus accept/reject decision; a byte always beats a gap expiry
  always_comb begin
    state_n = state;
    valid = 1'b0;
    err = 1'b0;
    if (strobe)
      case (state)
        IDLE: state_n = din == CMD_HEADER ? INDEX : IDLE;
        INDEX: state_n = DATA;
        DATA: state_n = cnt == CW'(NB - 1) ? CHECK : DATA;
        default: begin
          valid = din == acc && int'(idx) < NUM_CH;
          err = !valid;
          state_n = IDLE;
        end
      endcase
    else if (byte_expired) begin
      state_n = IDLE;
      err = 1'b1;
    end
  end
  // index latch, payload shift register and running checksum
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
      cnt <= '0;
      shadow <= '0;
    end else if (strobe)
      case (state)
        INDEX: begin
          idx <= din;
          acc <= din;
          cnt <= '0;
        end
        DATA: begin
          shadow <= DATA_WIDTH'({shadow, din});
          acc <= acc ^ din;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
  // one-cycle status pulses, registered alongside the target write
  always_ff @(posedge clk)
    if (!rst_n) begin
      update <= 1'b0;
      error <= 1'b0;
    end else begin
      update <= valid;
      error <= err;
    end
`ifdef CMD_WATCHDOG_EN
  logic wd_expired, timeout;
  // link-loss watchdog: restarted by every accepted frame
  cmd_timeout_counter #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk(clk), .rst_n(rst_n), .clear(valid), .enable(1'b1), .expired(wd_expired)
  );
  // target bank: a valid frame beats the failsafe and lifts it
  always_ff @(posedge clk)
    if (!rst_n) begin
      targets <= '0;
      timeout <= 1'b0;
    end else if (valid) begin
      targets[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= shadow;
      timeout <= 1'b0;
    end else if (wd_expired) begin
      targets <= '0;
      timeout <= 1'b1;
    end
  assign bus.CMD_FRAME_DECODER_TIMEOUT_Out = timeout;
`else
  // target bank: holds the last accepted value per channel
  always_ff @(posedge clk)
    if (!rst_n) targets <= '0;
    else if (valid) targets[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= shadow;
  assign bus.CMD_FRAME_DECODER_TIMEOUT_Out = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb_cmd_frame_decoder: directed and random frames checked against a frame-level model
module tb_cmd_frame_decoder;
  localparam int NUM_CH = 4;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int BT = 20;
  localparam int WD = 100;
  logic clk, rst_n, nd;
  logic [7:0] d;
  int checks, errors;
  logic chk_en;
  cmd_frame_decoder_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) bus ();
  assign bus.CMD_FRAME_DECODER_newData_In = nd;
  assign bus.CMD_FRAME_DECODER_data_InBus = d;
  wire [127:0] tg = bus.CMD_FRAME_DECODER_TARGETS_OutBus;
  wire up = bus.CMD_FRAME_DECODER_UPDATE_Out;
  wire er = bus.CMD_FRAME_DECODER_ERROR_Out;
  wire to = bus.CMD_FRAME_DECODER_TIMEOUT_Out;
  cmd_frame_decoder #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BYTE_TIMEOUT(BT), .WDOG_CYCLES(WD)) dut (
    .CMD_FRAME_DECODER_CLOCK_50(clk),
    .CMD_FRAME_DECODER_RESET_InLow(rst_n),
    .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic cmp(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  logic [127:0] m_targets;
  logic m_update, m_error, m_timeout;
  byte unsigned fr[$];
  int idle, wd;
  always @(posedge clk) begin
    logic [7:0] x;
    logic [31:0] p;
    logic v;
    v = 0;
    m_update = 0;
    m_error = 0;
    if (!rst_n) begin
      m_targets = 0;
      m_timeout = 0;
      fr.delete();
      idle = 0;
      wd = 0;
    end else begin
      if (nd) begin
        idle = 0;
        if (fr.size() > 0 || d == 8'hA5) fr.push_back(d);
        if (fr.size() == NB + 3) begin
          x = 0;
          p = 0;
          for (int i = 1; i <= NB + 1; i++) x ^= fr[i];
          for (int i = 2; i <= NB + 1; i++) p = {p[23:0], fr[i]};
          if (x == fr[NB+2] && int'(fr[1]) < NUM_CH) begin
            m_targets[int'(fr[1])*DW +: DW] = p;
            m_update = 1;
            m_timeout = 0;
            v = 1;
          end else m_error = 1;
          fr.delete();
        end
      end else if (fr.size() > 0) begin
        if (idle == BT) begin
          m_error = 1;
          fr.delete();
          idle = 0;
        end else idle++;
      end
`ifdef CMD_WATCHDOG_EN
      if (v) wd = 0;
      else if (wd == WD) begin
        m_targets = 0;
        m_timeout = 1;
      end else wd++;
`endif
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      cmp("targets", tg, m_targets);
      cmp("update", up, m_update);
      cmp("error", er, m_error);
      cmp("timeout", to, m_timeout);
      cmp("upd_err_excl", up & er, 0);
    end
  task automatic cyc(input logic v, input logic [7:0] b);
    @(posedge clk);
    #1;
    nd = v;
    d = b;
  endtask
  task automatic send_frame(input logic [7:0] ix, input logic [31:0] p, input logic [7:0] c);
    cyc(1, 8'hA5);
    cyc(1, ix);
    for (int i = 3; i >= 0; i--) cyc(1, p[i*8 +: 8]);
    cyc(1, c);
    cyc(0, 0);
  endtask
  initial begin
    int kind, gap;
    logic [7:0] ix, c;
    logic [31:0] p;
    byte unsigned q[$];
    checks = 0;
    errors = 0;
    chk_en = 0;
    rst_n = 0;
    nd = 0;
    d = 0;
    repeat (3) cyc(0, 0);
    rst_n = 1;
    chk_en = 1;
    cmp("reset_targets", tg, 0);
    cmp("reset_update", up, 0);
    cmp("reset_error", er, 0);
    cmp("reset_timeout", to, 0);
    send_frame(8'h01, 32'h00004000, 8'h41);
    cmp("t1_update", up, 1);
    cmp("t1_targets", tg, 128'h00000000_00000000_00004000_00000000);
    cyc(0, 0);
    cmp("t1_update_pulse", up, 0);
    send_frame(8'h01, 32'h00004000, 8'h42);
    cmp("t2_error", er, 1);
    cmp("t2_no_update", up, 0);
    cmp("t2_target1", tg[63:32], 32'h00004000);
    send_frame(8'h00, 32'h12345678, 8'h08);
    cmp("t2_ch0_update", up, 1);
    cmp("t2_ch0", tg[31:0], 32'h12345678);
    send_frame(8'h04, 32'h00000001, 8'h05);
    cmp("t3_error", er, 1);
    cmp("t3_targets", tg, 128'h00000000_00000000_00004000_12345678);
    cyc(1, 8'hA5);
    cyc(1, 8'h02);
    cyc(1, 8'h11);
    repeat (BT + 1) cyc(0, 0);
    cmp("t4_before_expiry", er, 0);
    cyc(0, 0);
    cmp("t4_expiry_error", er, 1);
    cyc(1, 8'hA5);
    cyc(1, 8'h02);
    cyc(1, 8'h11);
    repeat (BT) cyc(0, 0);
    cyc(1, 8'h22);
    cyc(1, 8'h33);
    cmp("t4_strobe_wins", er, 0);
    cyc(1, 8'h44);
    cyc(1, 8'h46);
    cyc(0, 0);
    cmp("t4_late_frame_update", up, 1);
    cmp("t4_late_frame_ch2", tg[95:64], 32'h11223344);
    cyc(1, 8'hA5);
    cyc(1, 8'h01);
    cyc(1, 8'hAA);
    cyc(0, 0);
    rst_n = 0;
    repeat (2) cyc(0, 0);
    rst_n = 1;
    cmp("t5_reset_clears", tg, 0);
    send_frame(8'h03, 32'h0A0B0C0D, 8'h03);
    cmp("t5_update", up, 1);
    cmp("t5_no_error", er, 0);
    cmp("t5_targets", tg, 128'h0A0B0C0D_00000000_00000000_00000000);
`ifdef CMD_WATCHDOG_EN
    send_frame(8'h00, 32'h00000001, 8'h01);
    send_frame(8'h01, 32'h00000002, 8'h03);
    repeat (WD) cyc(0, 0);
    cmp("t6_before_failsafe", to, 0);
    cyc(0, 0);
    cmp("t6_timeout", to, 1);
    cmp("t6_targets_zero", tg, 0);
    send_frame(8'h02, 32'h000000FF, 8'hFD);
    cmp("t6_timeout_clear", to, 0);
    cmp("t6_targets", tg, 128'h00000000_000000FF_00000000_00000000);
`endif
    repeat (400) begin
      kind = $urandom_range(0, 9);
      q.delete();
      if (kind == 0) q.push_back(8'($urandom));
      else begin
        ix = kind == 1 ? 8'($urandom) : 8'($urandom_range(0, NUM_CH));
        p = $urandom;
        if (kind == 3) p[15:8] = 8'hA5;
        c = ix ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
        if (kind == 2) c ^= 8'(1 << $urandom_range(0, 7));
        q.push_back(8'hA5);
        q.push_back(ix);
        for (int i = 3; i >= 0; i--) q.push_back(p[i*8 +: 8]);
        q.push_back(c);
      end
      foreach (q[i]) begin
        gap = $urandom_range(0, 99);
        gap = gap < 60 ? 0 : gap < 92 ? $urandom_range(1, 3) : $urandom_range(BT - 1, BT + 1);
        repeat (gap) begin
          cyc(0, 8'($urandom));
          rst_n = $urandom_range(0, 299) != 0;
        end
        rst_n = 1;
        cyc(1, q[i]);
      end
    end
    repeat (BT + 5) cyc(0, 0);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
